// File: rtl/motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : motion_sequencer
//  Description : Arbitrates autonomous (navigator) and manual motion commands,
//                turns each granted command into a timed motor pulse followed
//                by a motors-off settle dwell, and strobes nav_step once per
//                completed autonomous move.
//  Revision    : 1.0 - initial release
// ============================================================================
module motion_sequencer #(
    parameter int CNT_W         = 16,
    parameter int FWD_CYCLES    = 1000,
    parameter int TURN_CYCLES   = 2500,
    parameter int SETTLE_CYCLES = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic nav_front,
    input  logic nav_rotate,
    input  logic manual_en,
    input  logic man_front,
    input  logic man_rotate,
    input  logic head_obstacle,
    output logic motor_fwd,
    output logic motor_turn,
    output logic nav_step,
    output logic move_done,
    output logic abort,
    output logic busy,
    output logic src_manual
);

    // Counter reload values; each phase lasts (load + 1) cycles because the
    // state exits when the counter reaches zero.
    localparam logic [CNT_W-1:0] FWD_LOAD    = CNT_W'(FWD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MOVE_FWD = 2'd1,
        S_TURNING  = 2'd2,
        S_SETTLE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_src;
    logic             w_src_nxt;
    logic             r_nav_step;
    logic             w_nav_step_nxt;
    logic             r_move_done;
    logic             w_move_done_nxt;
    logic             r_abort;
    logic             w_abort_nxt;

    logic             w_req_front;
    logic             w_req_rotate;
    logic             w_cnt_zero;

    // Request mux: the selected source only matters while IDLE, because
    // grants are the only place these wires are consumed.
    assign w_req_front  = manual_en ? man_front  : nav_front;
    assign w_req_rotate = manual_en ? man_rotate : nav_rotate;
    assign w_cnt_zero   = (r_cnt == '0);

    // Next-state, counter and registered-pulse decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_src_nxt       = r_src;
        w_nav_step_nxt  = 1'b0;
        w_move_done_nxt = 1'b0;
        w_abort_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_req_rotate) begin
                    // Rotate wins over front when both are requested.
                    w_state_nxt = S_TURNING;
                    w_cnt_nxt   = TURN_LOAD;
                    w_src_nxt   = manual_en;
                end else if (w_req_front) begin
                    w_state_nxt = S_MOVE_FWD;
                    w_cnt_nxt   = FWD_LOAD;
                    w_src_nxt   = manual_en;
                end else begin
                    // Idle navigator gets nudged to re-evaluate; manual
                    // control never drives the navigator.
                    w_nav_step_nxt = ~manual_en;
                end
            end

            S_MOVE_FWD: begin
                if (head_obstacle) begin
                    // Obstacle abort beats normal completion on the same cycle.
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = SETTLE_LOAD;
                    w_abort_nxt = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = SETTLE_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            S_TURNING: begin
                // The obstacle sensor faces forward; it is irrelevant to turns.
                if (w_cnt_zero) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = SETTLE_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            S_SETTLE: begin
                if (w_cnt_zero) begin
                    w_state_nxt     = S_IDLE;
                    w_cnt_nxt       = '0;
                    w_move_done_nxt = 1'b1;
                    w_nav_step_nxt  = ~r_src;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, source latch and one-cycle pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_src       <= 1'b0;
            r_nav_step  <= 1'b0;
            r_move_done <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_src       <= w_src_nxt;
            r_nav_step  <= w_nav_step_nxt;
            r_move_done <= w_move_done_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    // Motor drives and busy are pure state decodes, so the two motors can
    // never be driven together and no input reaches an output combinationally.
    assign motor_fwd  = (r_state == S_MOVE_FWD);
    assign motor_turn = (r_state == S_TURNING);
    assign busy       = (r_state != S_IDLE);
    assign nav_step   = r_nav_step;
    assign move_done  = r_move_done;
    assign abort      = r_abort;
    assign src_manual = r_src;

endmodule
`default_nettype wire

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
- Sits between the wall-following navigator FSM and the motor drivers.
- Arbitrates commands from two sources: autonomous (navigator front/rotate) and manual (remote control).
- Converts each granted command into a timed motor pulse followed by a settle dwell.
- Strobes nav_step when an autonomous move completes, so the top level advances the navigator only once per physical move.

Parameters:
- CNT_W, 16: width of the duration counter.
- FWD_CYCLES, 1000: cycles motor_fwd is held per forward move; 1 to 2^CNT_W-1.
- TURN_CYCLES, 2500: cycles motor_turn is held per rotate move; 1 to 2^CNT_W-1.
- SETTLE_CYCLES, 200: motors-off dwell after every move; 1 to 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- nav_front  in  1  navigator forward request.
- nav_rotate  in  1  navigator rotate request.
- manual_en  in  1  selects the manual source; sampled only in IDLE.
- man_front  in  1  manual forward request.
- man_rotate  in  1  manual rotate request.
- head_obstacle  in  1  emergency front sensor; aborts forward moves.
- motor_fwd  out  1  forward motor drive.
- motor_turn  out  1  rotation motor drive.
- nav_step  out  1  one-cycle pulse; advance navigator.
- move_done  out  1  one-cycle pulse; any move finished (normal or aborted).
- abort  out  1  one-cycle pulse; forward move cut short.
- busy  out  1  high whenever state != IDLE.
- src_manual  out  1  source of the current or last granted move.

Behaviour:
- The design is a single clock domain clocked by clk, with synchronous active-high reset.
- Reset (from any state, including mid-move):
  - Next edge: state=IDLE, counter=0.
  - motor_fwd, motor_turn, nav_step, move_done, abort, busy, src_manual all 0.
- All outputs are registered or are pure decodes of registered state; there are no input-to-output combinational paths.
- States: IDLE, MOVE_FWD, TURNING, SETTLE.
- IDLE:
  - Selected source: man_* if manual_en=1, else nav_*.
  - Rotate request (regardless of front): -> TURNING, counter=TURN_CYCLES-1. Rotate has priority over front.
  - Front request only: -> MOVE_FWD, counter=FWD_CYCLES-1.
  - No request: stay in IDLE.
    - If the source is nav, pulse nav_step on the next cycle so the navigator re-evaluates.
    - If the source is manual, no pulse.
  - src_manual is latched to manual_en on every grant.
- MOVE_FWD:
  - motor_fwd=1 for exactly FWD_CYCLES cycles; counter decrements each cycle.
  - At counter==0: -> SETTLE, counter=SETTLE_CYCLES-1.
  - head_obstacle=1 in any MOVE_FWD cycle:
    - Next edge -> SETTLE, counter=SETTLE_CYCLES-1.
    - abort=1 for that first SETTLE cycle.
    - Abort takes priority over counter==0 on the same cycle.
- TURNING:
  - motor_turn=1 for exactly TURN_CYCLES cycles; head_obstacle is ignored.
  - At counter==0: -> SETTLE.
- SETTLE:
  - Both motors 0; counter decrements.
  - At counter==0: -> IDLE.
  - Registered pulses on the first IDLE cycle:
    - move_done=1.
    - nav_step=1 only if src_manual=0.
- Mutual exclusion: motor_fwd and motor_turn are never both 1; there is no direct MOVE_FWD<->TURNING transition, so SETTLE always separates them.
- Mid-move input changes: changes to manual_en, nav_* or man_* after a grant are ignored until the next IDLE.
- Latency:
  - Request seen in IDLE -> motor asserted at the next edge.
  - Total busy time per move = move cycles + SETTLE_CYCLES.
- Counter rules: loads are truncated to CNT_W bits; the counter never wraps below 0 (state exits at 0).

Test Plan (FWD_CYCLES=4, TURN_CYCLES=6, SETTLE_CYCLES=2 unless noted):
- Reset then nav_front=1, nav_rotate=0, manual_en=0 -> motor_fwd high exactly 4 cycles, 2 idle cycles, then move_done=1 and nav_step=1 for one cycle; busy high for 6 cycles.
- nav_front=1 and nav_rotate=1 together -> motor_turn high for 6 cycles; motor_fwd never asserted; nav_step pulses once after SETTLE.
- Forward move with head_obstacle pulsed in the 2nd MOVE_FWD cycle -> motor_fwd drops after 2 cycles; abort=1 and enters SETTLE; 2 cycles later move_done=1 and nav_step=1.
- manual_en=1, man_rotate=1 -> 6-cycle turn; move_done=1, nav_step=0, src_manual=1. Toggling manual_en mid-turn must not change the duration.
- Assert reset in the 3rd TURNING cycle -> next edge: motor_turn=0, busy=0, no move_done/nav_step pulse.
- Random stimulus, 10k cycles -> motor_fwd&motor_turn never 1. Every move_done is preceded by SETTLE_CYCLES cycles with both motors 0.
